// File: rtl/dircc_types_pkg.sv
// Shared DiRCC packet types and the packet-to-beat layout used by both the
// Avalon-ST transmitter and receiver.
package dircc_types_pkg;

  localparam int unsigned DIRCC_WORD_WIDTH   = 32;
  localparam int unsigned DIRCC_PACKET_WORDS = 8;
  localparam int unsigned DIRCC_EMPTY_WIDTH  = 2;
  localparam int unsigned DIRCC_IDX_WIDTH    = $clog2(DIRCC_PACKET_WORDS);

  typedef logic [DIRCC_WORD_WIDTH-1:0] word_t;
  typedef logic [DIRCC_IDX_WIDTH-1:0]  idx_t;

  localparam idx_t DIRCC_IDX_LAST = idx_t'(DIRCC_PACKET_WORDS - 1);

  typedef struct packed {
    logic [31:0] hw_addr;
    logic [15:0] sw_addr;
    logic [6:0]  port;
    logic        flag;
  } address_t;

  typedef struct packed {
    address_t     dest_addr;
    address_t     src_addr;
    logic [31:0]  lamport;
    logic [95:0]  data;
  } packet_t;

  typedef enum logic [0:0] {StIdle, StSend} tx_state_e;

  // Beat idx of a packet; the receiver parses exactly this layout.
  function automatic word_t dircc_packet_word(input packet_t pkt, input idx_t idx);
    word_t word;
    word = '0;
    case (idx)
      3'd0:    word = pkt.dest_addr.hw_addr;
      3'd1:    word = {pkt.dest_addr.sw_addr, pkt.dest_addr.port, pkt.dest_addr.flag, 8'h00};
      3'd2:    word = pkt.src_addr.hw_addr;
      3'd3:    word = {pkt.src_addr.sw_addr, pkt.src_addr.port, pkt.src_addr.flag, 8'h00};
      3'd4:    word = pkt.lamport;
      3'd5:    word = pkt.data[31:0];
      3'd6:    word = pkt.data[63:32];
      default: word = pkt.data[95:64];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/dircc_avalon_st_packet_transmitter_if.sv
// Avalon-ST 32-bit stream with packet framing; master is the data source.
interface dircc_avalon_st_packet_transmitter_if;
  import dircc_types_pkg::*;

  word_t                        data;
  logic                         valid;
  logic                         ready;
  logic                         startofpacket;
  logic                         endofpacket;
  logic [DIRCC_EMPTY_WIDTH-1:0] empty;

  modport master (
    output data, valid, startofpacket, endofpacket, empty,
    input  ready
  );

  modport slave (
    input  data, valid, startofpacket, endofpacket, empty,
    output ready
  );

endinterface

// File: rtl/dircc_avalon_st_packet_transmitter.sv
// Serialises one DiRCC packet into eight Avalon-ST beats; a new packet can be
// accepted in the same cycle the last beat fires so packets stream back-to-back.
module dircc_avalon_st_packet_transmitter
  import dircc_types_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    booting,
  input  packet_t packet_data,
  input  logic    packet_valid,
  output logic    packet_ready,
  output logic    send_nearly_done,
  output logic    send_done,
  dircc_avalon_st_packet_transmitter_if.master st
);

  tx_state_e state_q, state_d;
  idx_t      idx_q, idx_d;
  packet_t   pkt_q, pkt_d;
  logic      send_done_q, send_done_d;

  logic sending;
  logic last_beat;
  logic fire;
  logic accept;

  assign sending   = (state_q == StSend);
  assign last_beat = sending && (idx_q == DIRCC_IDX_LAST);
  assign fire      = sending && st.ready;

  // Reset is folded in so nothing is accepted during the reset cycle.
  assign packet_ready = !reset && !booting && (!sending || (last_beat && st.ready));
  assign accept       = packet_valid && packet_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pkt_d       = pkt_q;
    send_done_d = fire && last_beat;
    if (accept) begin
      pkt_d   = packet_data;
      idx_d   = '0;
      state_d = StSend;
    end else if (fire) begin
      if (last_beat) begin
        idx_d   = '0;
        state_d = StIdle;
      end else begin
        idx_d = idx_q + idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      pkt_q       <= '0;
      send_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pkt_q       <= pkt_d;
      send_done_q <= send_done_d;
    end
  end

  assign st.valid         = sending;
  assign st.data          = sending ? dircc_packet_word(pkt_q, idx_q) : '0;
  assign st.startofpacket = sending && (idx_q == '0);
  assign st.endofpacket   = last_beat;
  assign st.empty         = '0;

  assign send_nearly_done = last_beat;
  assign send_done        = send_done_q;

endmodule

// File: tb/tb_dircc_avalon_st_packet_transmitter.sv
// Scoreboarded random and directed bench for the Avalon-ST packet transmitter.
module tb_dircc_avalon_st_packet_transmitter;
  import dircc_types_pkg::*;

  typedef struct {
    logic [31:0] data;
    bit          sop;
    bit          eop;
  } beat_t;

  logic    clk = 1'b0;
  logic    reset;
  logic    booting;
  packet_t packet_data;
  logic    packet_valid;
  logic    packet_ready;
  logic    send_nearly_done;
  logic    send_done;

  dircc_avalon_st_packet_transmitter_if st_if();

  dircc_avalon_st_packet_transmitter dut (
    .clk              (clk),
    .reset            (reset),
    .booting          (booting),
    .packet_data      (packet_data),
    .packet_valid     (packet_valid),
    .packet_ready     (packet_ready),
    .send_nearly_done (send_nearly_done),
    .send_done        (send_done),
    .st               (st_if)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int fires_total = 0;
  int done_cnt = 0;
  int run_len = 0;
  int max_run = 0;
  int rmode = 0;

  beat_t       exp_q[$];
  packet_t     sent_q[$];
  logic [31:0] spec_words[8];
  logic [31:0] rx_words[8];
  int          rx_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: beats derived arithmetically from packet fields.
  task automatic push_model(input packet_t p);
    logic [31:0] w[8];
    w[0] = p.dest_addr.hw_addr;
    w[1] = 32'(p.dest_addr.sw_addr) * 32'h10000 + 32'(p.dest_addr.port) * 32'd512
         + 32'(p.dest_addr.flag) * 32'd256;
    w[2] = p.src_addr.hw_addr;
    w[3] = 32'(p.src_addr.sw_addr) * 32'h10000 + 32'(p.src_addr.port) * 32'd512
         + 32'(p.src_addr.flag) * 32'd256;
    w[4] = p.lamport;
    for (int i = 0; i < 3; i++) w[5+i] = 32'(p.data >> (32 * i));
    for (int i = 0; i < 8; i++) exp_q.push_back('{data: w[i], sop: (i == 0), eop: (i == 7)});
    sent_q.push_back(p);
  endtask

  task automatic push_literal(input packet_t p);
    for (int i = 0; i < 8; i++)
      exp_q.push_back('{data: spec_words[i], sop: (i == 0), eop: (i == 7)});
    sent_q.push_back(p);
  endtask

  function automatic packet_t rand_pkt();
    packet_t p;
    p.dest_addr.hw_addr = $urandom;
    p.dest_addr.sw_addr = 16'($urandom);
    p.dest_addr.port    = 7'($urandom);
    p.dest_addr.flag    = 1'($urandom);
    p.src_addr.hw_addr  = $urandom;
    p.src_addr.sw_addr  = 16'($urandom);
    p.src_addr.port     = 7'($urandom);
    p.src_addr.flag     = 1'($urandom);
    p.lamport           = $urandom;
    p.data              = {$urandom, $urandom, $urandom};
    return p;
  endfunction

  // Entered and left at posedge+1.
  task automatic send_pkt(input packet_t p, input bit literal);
    bit done;
    done = 0;
    packet_data  = p;
    packet_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (packet_ready) begin
        if (literal) push_literal(p);
        else push_model(p);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check("accept_timeout", 0, 1);
    packet_valid = 1'b0;
    packet_data  = rand_pkt(); // must not affect beats already in flight
  endtask

  task automatic wait_fires(input int n);
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      #1;
      if (fires_total >= n) done = 1;
    end
    if (!done) check("fire_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #1;
    case (rmode)
      0:       st_if.ready = 1'b1;
      1:       st_if.ready = !st_if.ready;
      2:       st_if.ready = ($urandom_range(0, 3) != 0);
      default: st_if.ready = 1'b0;
    endcase
  end

  // Monitor / scoreboard and behavioural receiver.
  bit          last_eop_fire = 0;
  bit          stalled_prev = 0;
  logic [34:0] prev_beat;
  always @(negedge clk) begin
    if (reset) begin
      last_eop_fire = 0;
      stalled_prev  = 0;
      run_len       = 0;
    end else begin
      bit    fire;
      beat_t e;
      packet_t got;
      fire = st_if.valid && st_if.ready;
      check("send_done", send_done, last_eop_fire);
      if (send_done) done_cnt++;
      if (stalled_prev)
        check("stall_hold", {st_if.valid, st_if.startofpacket, st_if.endofpacket, st_if.data},
              prev_beat);
      if (st_if.valid) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("nearly_done", send_nearly_done, exp_q[0].eop);
      end else begin
        check("nearly_done_idle", send_nearly_done, 0);
      end
      if (fire && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", {st_if.empty, st_if.startofpacket, st_if.endofpacket, st_if.data},
              {2'b00, e.sop, e.eop, e.data});
        fires_total++;
        if (st_if.startofpacket) rx_cnt = 0;
        if (rx_cnt < 8) rx_words[rx_cnt] = st_if.data;
        rx_cnt++;
        if (st_if.endofpacket && sent_q.size() != 0) begin
          got.dest_addr.hw_addr = rx_words[0];
          got.dest_addr.sw_addr = rx_words[1][31:16];
          got.dest_addr.port    = rx_words[1][15:9];
          got.dest_addr.flag    = rx_words[1][8];
          got.src_addr.hw_addr  = rx_words[2];
          got.src_addr.sw_addr  = rx_words[3][31:16];
          got.src_addr.port     = rx_words[3][15:9];
          got.src_addr.flag     = rx_words[3][8];
          got.lamport           = rx_words[4];
          got.data              = {rx_words[7], rx_words[6], rx_words[5]};
          check("loopback_pkt", {rx_cnt == 8, got}, {1'b1, sent_q.pop_front()});
        end
      end
      run_len = fire ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      stalled_prev  = st_if.valid && !st_if.ready;
      prev_beat     = {1'b1, st_if.startofpacket, st_if.endofpacket, st_if.data};
      last_eop_fire = fire && st_if.endofpacket;
    end
  end

  initial begin
    packet_t spec_pkt;
    packet_t p;
    int      base;
    int      done0;

    spec_words = '{32'h11223344, 32'h55660600, 32'hAABBCCDD, 32'h01020A00,
                   32'h00000007, 32'h04030201, 32'h08070605, 32'h0C0B0A09};
    spec_pkt.dest_addr = '{hw_addr: 32'h11223344, sw_addr: 16'h5566, port: 7'd3, flag: 1'b0};
    spec_pkt.src_addr  = '{hw_addr: 32'hAABBCCDD, sw_addr: 16'h0102, port: 7'd5, flag: 1'b0};
    spec_pkt.lamport   = 32'd7;
    spec_pkt.data      = 96'h0C0B0A09_08070605_04030201;

    reset        = 1'b1;
    booting      = 1'b0;
    packet_valid = 1'b0;
    packet_data  = '0;
    st_if.ready  = 1'b1;

    // Reset
    repeat (9) @(posedge clk);
    packet_valid = 1'b1;
    @(negedge clk);
    check("reset_ready", packet_ready, 0);
    check("reset_valid", {st_if.valid, st_if.startofpacket, st_if.endofpacket, st_if.data}, 0);
    @(posedge clk);
    #1;
    packet_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset", {st_if.valid, send_done, send_nearly_done, packet_ready}, 4'b0001);
    @(posedge clk);
    #1;

    // Single directed packet, ready held high
    send_pkt(spec_pkt, 1);
    drain(100);

    // Backpressure with a long stall on W3
    rmode = 1;
    base = fires_total;
    send_pkt(spec_pkt, 1);
    wait_fires(base + 3);
    rmode = 3;
    repeat (20) @(posedge clk);
    rmode = 1;
    drain(200);
    rmode = 0;

    // Booting holds off acceptance
    booting      = 1'b1;
    p            = rand_pkt();
    packet_data  = p;
    packet_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("booting_block", {packet_ready, st_if.valid}, 2'b00);
    end
    @(posedge clk);
    #1;
    booting = 1'b0;
    @(negedge clk);
    check("boot_release_ready", packet_ready, 1);
    push_model(p);
    @(posedge clk);
    #1;
    packet_valid = 1'b0;
    @(negedge clk);
    check("boot_latency", {st_if.valid, st_if.startofpacket}, 2'b11);
    drain(100);

    // Booting raised mid-packet: packet completes, next one is held off
    base = fires_total;
    send_pkt(rand_pkt(), 0);
    wait_fires(base + 4);
    booting      = 1'b1;
    packet_data  = rand_pkt();
    packet_valid = 1'b1;
    drain(100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("boot_mid_idle", {packet_ready, st_if.valid}, 2'b00);
    end
    @(posedge clk);
    #1;
    packet_valid = 1'b0;
    booting = 1'b0;

    // Back-to-back streaming
    done0 = done_cnt;
    max_run = 0;
    for (int i = 0; i < 3; i++) send_pkt(rand_pkt(), 0);
    drain(100);
    check("b2b_run", max_run, 24);
    check("b2b_done_pulses", done_cnt - done0, 3);

    // Reset after W3 fires truncates the packet
    base = fires_total;
    send_pkt(rand_pkt(), 0);
    wait_fires(base + 4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_mid", {st_if.valid, packet_ready, send_done}, 3'b000);
    exp_q.delete();
    if (sent_q.size() != 0) void'(sent_q.pop_front());
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_mid_idle", {st_if.valid, st_if.endofpacket}, 2'b00);
    @(posedge clk);
    #1;
    send_pkt(rand_pkt(), 0);
    drain(100);

    // Random traffic with random sink backpressure
    rmode = 2;
    for (int i = 0; i < 20; i++) begin
      send_pkt(rand_pkt(), 0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
    drain(2000);
    rmode = 0;
    repeat (3) @(posedge clk);

    check("queues_empty", {32'(exp_q.size()), 32'(sent_q.size())}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
